// File: rtl/gbf_pkg.sv
// Shared types and constants for the global-buffer weight RAM sequencers.
package gbf_pkg;

  localparam int unsigned GBF_WIDTH  = 32;
  localparam int unsigned GBF_HEIGHT = 48;
  localparam int unsigned GBF_ADDR_W = $clog2(GBF_HEIGHT);
  localparam int unsigned GBF_CNT_W  = 8;
  localparam int unsigned GBF_LANES  = 4;
  localparam int unsigned GBF_BEAT_W = GBF_LANES * GBF_WIDTH;
  // Two spare bits cover ptr + 3 (or + 4) without overflow.
  localparam int unsigned GBF_SUM_W  = GBF_ADDR_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } gbf_state_e;

  // Lane i carries RAM port a+i; lane 0 (port a) sits in the LSBs.
  typedef struct packed {
    logic [GBF_WIDTH-1:0] d;
    logic [GBF_WIDTH-1:0] c;
    logic [GBF_WIDTH-1:0] b;
    logic [GBF_WIDTH-1:0] a;
  } gbf_beat_t;

  typedef struct packed {
    logic [GBF_ADDR_W-1:0] d;
    logic [GBF_ADDR_W-1:0] c;
    logic [GBF_ADDR_W-1:0] b;
    logic [GBF_ADDR_W-1:0] a;
  } gbf_addr_t;

  // (ptr + ofs) mod HEIGHT; one conditional subtract is exact while ptr < HEIGHT.
  function automatic logic [GBF_ADDR_W-1:0] gbf_wrap_add(input logic [GBF_ADDR_W-1:0] ptr,
                                                         input logic [2:0]            ofs);
    logic [GBF_SUM_W-1:0] sum;
    sum = GBF_SUM_W'(ptr) + GBF_SUM_W'(ofs);
    if (sum >= GBF_SUM_W'(GBF_HEIGHT)) begin
      sum = sum - GBF_SUM_W'(GBF_HEIGHT);
    end
    return sum[GBF_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/gbf_addr_gen.sv
// Wrapped four-port address window and next window pointer; shared with the write-side loader.
module gbf_addr_gen
  import gbf_pkg::*;
(
  input  logic [GBF_ADDR_W-1:0] ptr_i,
  output gbf_addr_t             addr_o,
  output logic [GBF_ADDR_W-1:0] ptr_next_o
);

  // Consecutive addresses for ports a..d and the pointer one window ahead.
  always_comb begin
    addr_o.a   = gbf_wrap_add(ptr_i, 3'd0);
    addr_o.b   = gbf_wrap_add(ptr_i, 3'd1);
    addr_o.c   = gbf_wrap_add(ptr_i, 3'd2);
    addr_o.d   = gbf_wrap_add(ptr_i, 3'd3);
    ptr_next_o = gbf_wrap_add(ptr_i, 3'd4);
  end

endmodule

// File: rtl/gbf_weight_fetch.sv
// Read sequencer: walks a wrap-around window of the weight RAM and streams 4-word beats.
module gbf_weight_fetch
  import gbf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [GBF_ADDR_W-1:0] base_addr_i,
  input  logic [GBF_CNT_W-1:0]  num_beats_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [GBF_ADDR_W-1:0] addr_a_o,
  output logic [GBF_ADDR_W-1:0] addr_b_o,
  output logic [GBF_ADDR_W-1:0] addr_c_o,
  output logic [GBF_ADDR_W-1:0] addr_d_o,
  input  logic [GBF_WIDTH-1:0]  q_a_i,
  input  logic [GBF_WIDTH-1:0]  q_b_i,
  input  logic [GBF_WIDTH-1:0]  q_c_i,
  input  logic [GBF_WIDTH-1:0]  q_d_i,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic [GBF_BEAT_W-1:0] w_data_o,
  output logic                  w_last_o
);

  gbf_state_e            state_q, state_d;
  logic [GBF_ADDR_W-1:0] ptr_q, ptr_d;
  logic [GBF_ADDR_W-1:0] nxt_q, nxt_d;
  logic [GBF_CNT_W-1:0]  rem_q, rem_d;
  gbf_addr_t             addr_q, addr_d;
  gbf_beat_t             data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  gbf_addr_t             gen_addr;
  logic [GBF_ADDR_W-1:0] gen_next;
  logic                  load_c;

  // Address window for the pointer about to be registered; next window kept alongside.
  gbf_addr_gen u_addr_gen (
    .ptr_i      (ptr_d),
    .addr_o     (gen_addr),
    .ptr_next_o (gen_next)
  );

  // Output register can take a new beat when empty or draining this cycle.
  assign load_c = (state_q == ST_FETCH) && (!valid_q || w_ready_i) && (rem_q != '0);

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    nxt_d   = nxt_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    valid_d = valid_q;
    last_d  = last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (32'(base_addr_i) >= GBF_HEIGHT) begin
            err_d = 1'b1;
          end else if (num_beats_i == '0) begin
            done_d = 1'b1;
          end else begin
            ptr_d   = base_addr_i;
            rem_d   = num_beats_i;
            busy_d  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (valid_q && w_ready_i) begin
          valid_d = 1'b0;
        end
        if (load_c) begin
          valid_d     = 1'b1;
          data_d.a    = q_a_i;
          data_d.b    = q_b_i;
          data_d.c    = q_c_i;
          data_d.d    = q_d_i;
          last_d      = (rem_q == GBF_CNT_W'(1));
          rem_d       = rem_q - GBF_CNT_W'(1);
          ptr_d       = nxt_q;
          if (rem_q == GBF_CNT_W'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (valid_q && w_ready_i) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Addresses only move together with the pointer, so they hold under backpressure.
    if (ptr_d != ptr_q || (state_q == ST_IDLE && state_d == ST_FETCH)) begin
      addr_d = gen_addr;
      nxt_d  = gen_next;
    end
  end

  // State and output registers; reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      nxt_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      nxt_q   <= nxt_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign addr_a_o  = addr_q.a;
  assign addr_b_o  = addr_q.b;
  assign addr_c_o  = addr_q.c;
  assign addr_d_o  = addr_q.d;
  assign w_valid_o = valid_q;
  assign w_data_o  = data_q;
  assign w_last_o  = last_q;

endmodule

// File: tb/tb_gbf_weight_fetch.sv
// Scoreboard bench for gbf_weight_fetch against a RAM preloaded with ram[i] = i.
module tb_gbf_weight_fetch;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [5:0]   base_addr;
  logic [7:0]   num_beats;
  logic         busy, done, err;
  logic [5:0]   addr_a, addr_b, addr_c, addr_d;
  logic [31:0]  q_a, q_b, q_c, q_d;
  logic         w_valid, w_ready, w_last;
  logic [127:0] w_data;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           done_seen = 0;
  int           err_seen = 0;
  int           hs_seen = 0;
  logic [31:0]  ram [48];
  logic         bp_mode = 1'b0;
  logic         held_v = 1'b0;
  logic [127:0] held_data;
  logic         held_last;

  gbf_weight_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .num_beats_i (num_beats),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .addr_a_o    (addr_a),
    .addr_b_o    (addr_b),
    .addr_c_o    (addr_c),
    .addr_d_o    (addr_d),
    .q_a_i       (q_a),
    .q_b_i       (q_b),
    .q_c_i       (q_c),
    .q_d_i       (q_d),
    .w_valid_o   (w_valid),
    .w_ready_i   (w_ready),
    .w_data_o    (w_data),
    .w_last_o    (w_last)
  );

  initial begin
    for (int i = 0; i < 48; i++) ram[i] = 32'(i);
  end

  assign q_a = (addr_a < 6'd48) ? ram[addr_a] : 32'hdead_beef;
  assign q_b = (addr_b < 6'd48) ? ram[addr_b] : 32'hdead_beef;
  assign q_c = (addr_c < 6'd48) ? ram[addr_c] : 32'hdead_beef;
  assign q_d = (addr_d < 6'd48) ? ram[addr_d] : 32'hdead_beef;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] beat(input int d, input int c, input int b, input int a);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic push(input logic [127:0] data, input logic last);
    exp_t e;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Ready generator: held high, or the 1,0,0,1 pattern while bp_mode is set.
  initial begin
    int idx;
    idx = 0;
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        w_ready = ((idx % 4) == 0) || ((idx % 4) == 3);
        idx++;
      end else begin
        idx = 0;
        w_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", 128'(w_valid), 128'(1));
        chk("hold_data", w_data, held_data);
        chk("hold_last", 128'(w_last), 128'(held_last));
      end
      if (w_valid && w_ready) begin
        hs_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=0x%0h required=none", w_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", w_data, e.data);
          chk("beat_last", 128'(w_last), 128'(e.last));
        end
      end
      held_v    = w_valid && !w_ready;
      held_data = w_data;
      held_last = w_last;
      if (done) begin
        done_seen++;
        chk("done_busy_low", 128'(busy), 128'(0));
      end
      if (err) err_seen++;
    end
  end

  // Pulses start for one sampling edge; returns #1 after that edge.
  task automatic start_fetch(input int base, input int num);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 6'(base);
    num_beats = 8'(num);
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && !w_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_drain"}, 128'(ok), 128'(1));
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctrl"}, 128'({busy, done, err, w_valid, w_last}), 128'(0));
    chk({name, "_data"}, w_data, 128'(0));
    chk({name, "_addr"}, 128'({addr_d, addr_c, addr_b, addr_a}), 128'(0));
  endtask

  initial begin
    int  hs0;
    bit  got;
    rst_n     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_beats = '0;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic fetch: three beats from address 0, first beat two edges after start.
    push(beat(3, 2, 1, 0), 1'b0);
    push(beat(7, 6, 5, 4), 1'b0);
    push(beat(11, 10, 9, 8), 1'b1);
    start_fetch(0, 3);
    chk("basic_busy", 128'(busy), 128'(1));
    chk("basic_valid_early", 128'(w_valid), 128'(0));
    chk("basic_addr", 128'({addr_d, addr_c, addr_b, addr_a}), 128'({6'd3, 6'd2, 6'd1, 6'd0}));
    @(posedge clk);
    #1 chk("basic_first_valid", 128'(w_valid), 128'(1));
    drain("basic");
    chk("basic_done_count", 128'(done_seen), 128'(1));

    // Wrap-around across the top of the RAM.
    push(beat(1, 0, 47, 46), 1'b0);
    push(beat(5, 4, 3, 2), 1'b1);
    start_fetch(46, 2);
    chk("wrap_addr", 128'({addr_d, addr_c, addr_b, addr_a}), 128'({6'd1, 6'd0, 6'd47, 6'd46}));
    drain("wrap");
    chk("wrap_done_count", 128'(done_seen), 128'(2));

    // Backpressure with ready toggling 1,0,0,1.
    bp_mode = 1'b1;
    push(beat(23, 22, 21, 20), 1'b0);
    push(beat(27, 26, 25, 24), 1'b0);
    push(beat(31, 30, 29, 28), 1'b0);
    push(beat(35, 34, 33, 32), 1'b1);
    hs0 = hs_seen;
    start_fetch(20, 4);
    drain("bp");
    bp_mode = 1'b0;
    chk("bp_handshakes", 128'(hs_seen - hs0), 128'(4));
    chk("bp_done_count", 128'(done_seen), 128'(3));

    // Out-of-range base: err pulse, never busy.
    start_fetch(48, 2);
    chk("err_pulse", 128'(err), 128'(1));
    chk("err_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1 chk("err_clear", 128'({err, busy, w_valid}), 128'(0));

    // Zero beats: done pulse with no beats and no busy.
    start_fetch(5, 0);
    chk("zero_done", 128'(done), 128'(1));
    chk("zero_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1 chk("zero_clear", 128'({done, busy, w_valid}), 128'(0));
    chk("zero_done_count", 128'(done_seen), 128'(4));

    // Starts during FETCH are ignored, including an out-of-range one.
    push(beat(15, 14, 13, 12), 1'b0);
    push(beat(19, 18, 17, 16), 1'b0);
    push(beat(23, 22, 21, 20), 1'b0);
    push(beat(27, 26, 25, 24), 1'b1);
    start_fetch(12, 4);
    start_fetch(48, 1);
    start_fetch(0, 2);
    drain("ignore");
    chk("ignore_err_count", 128'(err_seen), 128'(1));
    chk("ignore_done_count", 128'(done_seen), 128'(5));

    // Reset after the third of eight beats.
    for (int k = 0; k < 8; k++) push(beat(4*k+3, 4*k+2, 4*k+1, 4*k), (k == 7));
    hs0 = hs_seen;
    start_fetch(0, 8);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (hs_seen - hs0 >= 3) begin
        got = 1'b1;
        break;
      end
    end
    chk("midrst_third_beat", 128'(got), 128'(1));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 chk_zero("midrst_hold");
    rst_n = 1'b1;
    chk("midrst_no_done", 128'(done_seen), 128'(5));

    // Recovery fetch after reset.
    push(beat(11, 10, 9, 8), 1'b1);
    start_fetch(8, 1);
    drain("recover");
    chk("recover_done_count", 128'(done_seen), 128'(6));
    chk("final_err_count", 128'(err_seen), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
